// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
    localparam logic [31:0] OVF_QUOT  = 32'h80000000;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, the first
// bit is produced on the same edge that loads the operands.
module muldiv_divider
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic [4:0]  steps_r;
    logic        active_r;
    logic [63:0] first_s;
    logic [63:0] next_s;

    // One restoring step; returns {remainder, quotient}.
    function automatic logic [63:0] div_step(input logic [31:0] rem,
                                             input logic [31:0] quo,
                                             input logic [31:0] dvs);
        logic [32:0] shifted;
        logic [32:0] diff;
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[32]) begin
            div_step = {diff[31:0], quo[30:0], 1'b1};
        end else begin
            div_step = {shifted[31:0], quo[30:0], 1'b0};
        end
    endfunction

    assign first_s   = div_step(32'd0, dividend, divisor);
    assign next_s    = div_step(rem_r, quo_r, dvs_r);
    assign done      = active_r && (steps_r == 5'd0);
    assign quotient  = quo_r;
    assign remainder = rem_r;

    // Load-and-first-step on start, then DIV_ITERS-1 further steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= 1'b0;
            steps_r  <= 5'd0;
            quo_r    <= 32'd0;
            rem_r    <= 32'd0;
            dvs_r    <= 32'd0;
        end else if (abort) begin
            active_r <= 1'b0;
        end else if (start) begin
            active_r       <= 1'b1;
            steps_r        <= 5'(DIV_ITERS - 1);
            dvs_r          <= divisor;
            {rem_r, quo_r} <= first_s;
        end else if (active_r && (steps_r != 5'd0)) begin
            {rem_r, quo_r} <= next_s;
            steps_r        <= steps_r - 5'd1;
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// RV32M multiply/divide unit in Execute: owns the FSM, sign handling,
// the multiplier and divide special cases; stalls the pipe via MulDivBusy.
module execute_muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StartE,
    input  logic [2:0]            MulDivOpE,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    input  logic                  AbortE,
    output logic                  MulDivBusy,
    output logic                  MulDivDone,
    output logic [DATA_WIDTH-1:0] MulDivResultE
);

    muldiv_state_t state;
    muldiv_op_t    op_r;
    logic [31:0]   a_r;
    logic [31:0]   b_r;
    logic [4:0]    cnt_r;
    logic [31:0]   result_r;

    logic          in_signed;
    logic          in_div0;
    logic          in_ovf;
    logic [31:0]   special_res;
    logic          div_start;
    logic          div_done;
    logic [31:0]   div_quo;
    logic [31:0]   div_rem;
    logic          a_sx;
    logic          b_sx;
    logic [32:0]   a_ext;
    logic [32:0]   b_ext;
    logic [63:0]   prod;
    logic          r_signed;
    logic [31:0]   q_fix;
    logic [31:0]   r_fix;

    // Start-cycle decode works on the live operands; funct3[0] = unsigned, [1] = remainder.
    assign in_signed   = !MulDivOpE[0];
    assign in_div0     = (SrcBE == 32'd0);
    assign in_ovf      = in_signed && (SrcAE == 32'h80000000) && (SrcBE == 32'hFFFFFFFF);
    assign special_res = in_div0 ? (MulDivOpE[1] ? SrcAE : DIV0_QUOT)
                                 : (MulDivOpE[1] ? 32'd0 : OVF_QUOT);
    assign div_start   = (state == IDLE) && StartE && !AbortE && MulDivOpE[2]
                         && !in_div0 && !in_ovf;

    muldiv_divider u_divider (
        .clk       (clk),
        .rst       (rst),
        .abort     (AbortE),
        .start     (div_start),
        .dividend  (abs32(SrcAE, in_signed)),
        .divisor   (abs32(SrcBE, in_signed)),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // 33-bit operand extension makes one signed multiply cover all four variants.
    assign a_sx  = ((op_r == OP_MULH) || (op_r == OP_MULHSU)) && a_r[31];
    assign b_sx  = (op_r == OP_MULH) && b_r[31];
    assign a_ext = {a_sx, a_r};
    assign b_ext = {b_sx, b_r};
    assign prod  = $signed({{31{a_ext[32]}}, a_ext}) * $signed({{31{b_ext[32]}}, b_ext});

    assign r_signed = !op_r[0];
    assign q_fix    = (r_signed && (a_r[31] ^ b_r[31])) ? (32'd0 - div_quo) : div_quo;
    assign r_fix    = (r_signed && a_r[31]) ? (32'd0 - div_rem) : div_rem;

    assign MulDivBusy    = ((state == IDLE) && StartE && !AbortE) || (state == MUL) || (state == DIV);
    assign MulDivDone    = (state == DONE);
    assign MulDivResultE = result_r;

    // Control FSM with registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_r     <= OP_MUL;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            cnt_r    <= 5'd0;
            result_r <= 32'd0;
        end else if (AbortE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (StartE) begin
                        op_r <= muldiv_op_t'(MulDivOpE);
                        a_r  <= SrcAE;
                        b_r  <= SrcBE;
                        if (!MulDivOpE[2]) begin
                            state <= MUL;
                        end else if (in_div0 || in_ovf) begin
                            result_r <= special_res;
                            state    <= DONE;
                        end else begin
                            cnt_r <= 5'(DIV_ITERS - 1);
                            state <= DIV;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    result_r <= (op_r == OP_MUL) ? prod[31:0] : prod[63:32];
                    state    <= DONE;
                end
                DIV: begin
                    if ((cnt_r == 5'd0) && div_done) begin
                        result_r <= op_r[1] ? r_fix : q_fix;
                        state    <= DONE;
                    end else begin
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Multi-cycle RV32M multiply/divide unit in the Execute stage, directly downstream of the D/E pipeline register. Consumes the forwarded E-stage operands and a M-extension opcode, and produces a 32-bit result. Holds `MulDivBusy` high to stall F, D and E until the result is valid. The E-stage result mux selects `MulDivResultE` in the cycle `MulDivDone` is high.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `StartE`  in  1  M-extension instruction valid in E (decoded in D, carried through D/E register).
- `MulDivOpE`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `SrcAE`  in  32  rs1 value after forwarding.
- `SrcBE`  in  32  rs2 value after forwarding.
- `AbortE`  in  1  kill the in-flight operation (FlushE of the instruction in E).
- `MulDivBusy`  out  1  stall request to the hazard unit.
- `MulDivDone`  out  1  result valid this cycle.
- `MulDivResultE`  out  32  result.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE with `StartE`=1 and `AbortE`=0 latches operands and op, then branches:
  - MUL..MULHU → MUL.
  - DIV/REM with divisor 0, or signed -2^31 / -1 → DONE, special result.
  - Other DIV/REM → DIV, iteration counter = 31.
- MUL computes the 64-bit product and registers it. It then goes to DONE.
  - Operands are extended to 33 bits: signed for MULH (both) and MULHSU (rs1 only), zero otherwise.
  - MUL returns product[31:0]; all MULH* return product[63:32].
- DIV is a restoring radix-2 divider on magnitudes, one quotient bit per cycle, 32 cycles.
  - The counter decrements each cycle; at counter 0 go to DONE.
  - Signed ops: negate the quotient if the operand signs differ. The remainder takes the dividend's sign.
- Special results:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Overflow: quotient = 0x80000000, remainder = 0.
- DONE: `MulDivDone`=1, `MulDivBusy`=0, result held. Unconditionally → IDLE next cycle.
  - `StartE` still high in DONE is the same instruction and is ignored.
- `MulDivBusy` = (IDLE & `StartE` & !`AbortE`) | MUL | DIV. It is combinational, so the instruction stalls in its first E cycle.
- `AbortE`=1 in any state → IDLE next cycle, no DONE pulse, result unchanged. `AbortE` beats `StartE`.
- `rst`=1 → IDLE next cycle, regardless of state.
  - Reset values: `MulDivBusy`=0, `MulDivDone`=0, `MulDivResultE`=0. Internal operand, remainder and counter registers = 0.

## Timing
- Latency from the first E cycle with `StartE` to the `MulDivDone` cycle:
  - MUL*: 2 cycles.
  - DIV/REM: 33 cycles.
  - Special-case divide: 1 cycle.
- `MulDivBusy` high for exactly latency cycles. The DONE cycle is the cycle the pipeline advances.
- `MulDivResultE` is registered, stable throughout DONE, and holds its value until the next DONE.
- Back-to-back M instructions: the second instruction's `StartE` arrives the cycle after DONE, finding the FSM in IDLE. There is no bubble beyond that.
- Operands are sampled only in the IDLE start cycle. Forwarding changes during a stall are ignored.

## Structure
- Package `muldiv_pkg`:
  - enum `muldiv_op_t` (8 funct3 codes).
  - enum `muldiv_state_t` (IDLE, MUL, DIV, DONE).
  - constants `DIV_ITERS`=32, `DIV0_QUOT`=32'hFFFFFFFF, `OVF_QUOT`=32'h80000000.
- Sub-module `muldiv_divider`: the iterative unsigned core. It has start, dividend, divisor, done, quotient and remainder ports, plus `rst`/abort. The top module owns the FSM, sign handling, multiply and special cases.

## Test plan
- MUL 7 × -3 (0xFFFFFFFD) → Busy 2 cycles, then Done with 0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH of the same operands → 0x00000000; MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD, then REM -7 / 2 → 0xFFFFFFFF. Each has Busy for exactly 33 cycles; the two run back-to-back with no extra bubble.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / -1 → 0x80000000; REM of the same operands → 0. Each has Busy for 1 cycle.
- `AbortE` on DIV iteration 10 → IDLE next cycle, no Done pulse, Busy low. A following MUL 3 × 4 → 12 with correct timing.
- `rst` asserted mid-DIV → next cycle Busy=0, Done=0, Result=0. A new DIVU 100 / 7 → 14 after 33 cycles.
